bin_note_lookup: RTL and testbench
==================================

Name: bin_note_lookup

Overview:
- Maps an FFT bin index to a musical note index, with 64 semitone notes from C2 (index 0, 65.406 Hz) to D#7 (index 63).
- Sits downstream of the FFT peak-picker in the music transcription pipeline.
- Accepts one bin per request and binary-searches a 64-entry lower-edge table.
- Returns the note index plus an in-range flag.

Parameters:
- SAMPLE_RATE, 8000, audio sample rate in Hz.
- NFFT, 1024, FFT length. Bin k frequency = k*SAMPLE_RATE/NFFT.
- BIN_W, 10, width of bin_index.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset.
- bin_index  input  BIN_W  FFT bin to classify, sampled on accept.
- ready_in  input  1  request strobe; accepted only when busy_out=0.
- note_index  output  6  note number, 0=C2 … 63=D#7.
- in_range_out  output  1  1 if the bin frequency lies inside the note range.
- valid_out  output  1  one-cycle pulse when note_index/in_range_out update.
- busy_out  output  1  high while a search is in progress.

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: note_index=0, in_range_out=0, valid_out=0, busy_out=0. Reset aborts any search in progress; no valid_out is produced for the aborted request.
- Note frequency: f_n = 440*2^((n-33)/12), so A4 is n=33.
- Lower-edge table: LOW_EDGE[n] = ceil(NFFT*f_n*2^(-1/24)/SAMPLE_RATE).
  - This is the smallest bin whose frequency is at or above the lower half-semitone boundary of note n.
  - HIGH_LIMIT = ceil(NFFT*f_63*2^(1/24)/SAMPLE_RATE), i.e. 328 at the defaults.
  - The table is a constant ROM computed at elaboration from the parameters.
- Classification, result = largest n with LOW_EDGE[n] <= bin:
  - bin < LOW_EDGE[0]: note 0, in_range 0.
  - bin >= HIGH_LIMIT: note 63, in_range 0.
  - Otherwise: in_range 1.
  - When adjacent notes share an edge (possible at low frequencies), the higher note wins.
- FSM states IDLE, SEARCH, DONE.
  - IDLE: busy_out=0. On ready_in=1 at a clock edge, latch bin_index, set busy_out=1, go to SEARCH.
  - SEARCH: six cycles of binary search over the 6-bit note index, MSB first. Bit b is set if LOW_EDGE[candidate with bit b set] <= latched bin. The range checks run in parallel with the search.
  - DONE: register the result, pulse valid_out for exactly one cycle, clear busy_out, return to IDLE.
- Latency: valid_out is high in the 8th cycle after the accepting edge (accept edge, 6 search edges, then the result edge).
- Throughput: a new request can be accepted in the cycle valid_out is high (DONE→IDLE, then accept on the next edge).
- Holding ready_in high continuously yields back-to-back lookups of whatever bin_index is present at each accept.
- ready_in asserted while busy_out=1 is ignored; requests are not queued.
- bin_index changes after the accept edge do not affect the result.
- note_index and in_range_out hold their last result until the next valid_out.

Test Plan:
- Reset: assert rst_in for 1 cycle -> note_index=0, in_range_out=0, valid_out=0, busy_out=0.
- Hold ready_in=1 with bin_index=215 (1679.7 Hz) -> valid_out pulses; note_index=56 (G#6), in_range_out=1, 8-cycle latency from accept. The result repeats for every subsequent lookup.
- Sweep the single-request table:
  - bin 56 -> note 33, in_range 1.
  - bin 9 -> note 1, in_range 1.
  - bin 8 -> note 0, in_range 0.
  - bin 327 -> note 63, in_range 1.
  - bin 328 -> note 63, in_range 0.
  - bin 1023 -> note 63, in_range 0.
- Busy rule: pulse ready_in with bin 215, then pulse it again 3 cycles later with bin 56 -> exactly one valid_out with note 56. A third request after valid_out gives note 33.
- Reset mid-search: accept bin 215, assert rst_in 3 cycles later -> no valid_out; all outputs at reset values; the next request completes normally.
- Input stability: change bin_index one cycle after accept -> the result reflects the originally latched bin.

Source files
------------

// File: rtl/bin_note_lookup.sv
// Maps an FFT bin index to a semitone note index (0 = C2 .. 63 = D#7).
// A six-step binary search runs over a lower-edge ROM built at elaboration.
module bin_note_lookup #(
  parameter int SAMPLE_RATE = 8000,
  parameter int NFFT        = 1024,
  parameter int BIN_W       = 10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [BIN_W-1:0] bin_index,
  input  logic             ready_in,
  output logic [5:0]       note_index,
  output logic             in_range_out,
  output logic             valid_out,
  output logic             busy_out
);

  // Smallest bin at or above note + half_steps/2 semitone, with A4 = note 33.
  function automatic int edge_bin(input int note, input int half_steps);
    real freq;
    real bin_real;
    freq     = 440.0 * (2.0 ** ((real'(note) - 33.0) / 12.0));
    bin_real = real'(NFFT) * freq * (2.0 ** (real'(half_steps) / 24.0)) / real'(SAMPLE_RATE);
    return $rtoi($ceil(bin_real));
  endfunction

  localparam int HIGH_LIMIT = edge_bin(63, 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  // One extra bit so edges and the bin compare without wrap-around.
  logic [BIN_W:0] low_edge [64];

  for (genvar g = 0; g < 64; g++) begin : g_rom
    localparam int EDGE = edge_bin(g, -1);
    assign low_edge[g] = EDGE[BIN_W:0];
  end

  state_t         state;
  state_t         state_next;
  logic [BIN_W:0] bin_q;
  logic [5:0]     result_q;
  logic [2:0]     bit_idx;
  logic [5:0]     candidate;
  logic           hit;
  logic           below;
  logic           above;
  logic           load;
  logic           step;
  logic           finish;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (ready_in) state_next = SEARCH;
      SEARCH:  if (bit_idx == 3'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    busy_out = 1'b1;
    case (state)
      IDLE:    begin load = ready_in; busy_out = 1'b0; end
      SEARCH:  step = 1'b1;
      DONE:    finish = 1'b1;
      default: busy_out = 1'b0;
    endcase
  end

  // Try setting the current bit; keep it if that note's lower edge is not above the bin.
  assign candidate = result_q | (6'd1 << bit_idx);
  assign hit       = (low_edge[candidate] <= bin_q);
  assign below     = (bin_q < low_edge[0]);
  assign above     = (bin_q >= HIGH_LIMIT[BIN_W:0]);

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      bin_q        <= '0;
      result_q     <= '0;
      bit_idx      <= '0;
      note_index   <= '0;
      in_range_out <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (load) begin
        bin_q    <= {1'b0, bin_index};
        result_q <= '0;
        bit_idx  <= 3'd5;
      end
      if (step) begin
        if (hit) result_q <= candidate;
        bit_idx <= bit_idx - 3'd1;
      end
      if (finish) begin
        note_index   <= above ? 6'd63 : result_q;
        in_range_out <= !below && !above;
        valid_out    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_note_lookup.sv
// Directed bench for bin_note_lookup: hand-computed note/range results,
// latency, busy rule, reset abort and input stability.
module tb_bin_note_lookup;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [9:0] bin_index = '0;
  logic       ready_in = 1'b0;
  logic [5:0] note_index;
  logic       in_range_out;
  logic       valid_out;
  logic       busy_out;

  int total = 0;
  int bad   = 0;

  bin_note_lookup dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .bin_index    (bin_index),
    .ready_in     (ready_in),
    .note_index   (note_index),
    .in_range_out (in_range_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Single request issued from a negedge; measures edges from accept to valid_out.
  task automatic lookup(input int bin, input int exp_note, input int exp_range);
    int lat;
    bin_index = 10'(bin);
    ready_in  = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    ready_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(posedge clk_in);
      lat++;
      @(negedge clk_in);
    end
    check($sformatf("lat_%0d", bin), lat, 8);
    check($sformatf("note_%0d", bin), note_index, exp_note);
    check($sformatf("range_%0d", bin), in_range_out, exp_range);
    check($sformatf("busy_at_valid_%0d", bin), busy_out, 0);
    @(negedge clk_in);
    check($sformatf("pulse_%0d", bin), valid_out, 0);
  endtask

  initial begin
    int valids;
    int gap;
    int last_note;

    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_note", note_index, 0);
    check("rst_range", in_range_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy_out, 0);

    // Held ready: back-to-back lookups of bin 215, one result every 8 cycles.
    bin_index = 10'd215;
    ready_in  = 1'b1;
    @(negedge clk_in);
    check("held_busy", busy_out, 1);
    gap = 1;
    while (!valid_out && gap < 20) begin
      @(negedge clk_in);
      gap++;
    end
    check("held_first_lat", gap, 8);
    check("held_note1", note_index, 56);
    check("held_range1", in_range_out, 1);
    gap = 0;
    do begin
      @(negedge clk_in);
      gap++;
    end while (!valid_out && gap < 20);
    check("held_period", gap, 8);
    check("held_note2", note_index, 56);
    ready_in = 1'b0;
    repeat (10) @(negedge clk_in);

    lookup(56, 33, 1);
    lookup(9, 1, 1);
    lookup(8, 0, 0);
    lookup(327, 63, 1);
    lookup(328, 63, 0);
    lookup(1023, 63, 0);
    lookup(215, 56, 1);

    // Busy rule: a second strobe 3 cycles into a search is dropped.
    lookup(8, 0, 0);
    bin_index = 10'd215;
    ready_in  = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    bin_index = 10'd56;
    ready_in  = 1'b1;
    @(negedge clk_in);
    ready_in  = 1'b0;
    valids    = 0;
    last_note = -1;
    for (int i = 0; i < 20; i++) begin
      if (valid_out) begin
        valids++;
        last_note = note_index;
      end
      @(negedge clk_in);
    end
    check("busy_valids", valids, 1);
    check("busy_note", last_note, 56);
    lookup(56, 33, 1);

    // Reset mid-search aborts the request with no valid_out.
    bin_index = 10'd215;
    ready_in  = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("abort_note", note_index, 0);
    check("abort_range", in_range_out, 0);
    check("abort_busy", busy_out, 0);
    valids = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid_out) valids++;
      @(negedge clk_in);
    end
    check("abort_valids", valids, 0);
    lookup(9, 1, 1);

    // bin_index changes after accept must not leak into the result.
    bin_index = 10'd56;
    ready_in  = 1'b1;
    @(negedge clk_in);
    ready_in  = 1'b0;
    bin_index = 10'd215;
    gap = 1;
    while (!valid_out && gap < 20) begin
      @(negedge clk_in);
      gap++;
    end
    check("stable_lat", gap, 8);
    check("stable_note", note_index, 33);
    check("stable_range", in_range_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
